// File: rtl/shadowmask_cmd_gen.sv
// shadowmask_cmd_gen
// Command transmitter for the shadow-mask post-processor. It buffers a mask LUT
// image, and on each accepted start it emits HDR, VMAX, HMAX and then LUT
// entries 0..N-1 as cmd_wr/cmd_out strobes, with GAP idle cycles between
// consecutive strobes.
//
// Parameters
//   GAP        idle cycles between consecutive cmd_wr strobes (0..15)
// Ports
//   clk_sys    system clock (the only clock)
//   reset      synchronous, active-high reset
//   cfg_*      header / pattern-size fields, latched on the accepted start
//   lut_count  number of LUT entries to send (clamped to 256)
//   lut_wr/lut_addr/lut_data   LUT buffer write port (ignored while busy)
//   start      single-cycle transmit request
//   busy       sequence in progress
//   done       one-cycle pulse after the final command
//   cmd_wr     command strobe
//   cmd_out    command word (registered, holds between strobes)
//   csum       running 16-bit sum of emitted words
// Build option
//   SHADOWMASK_CMD_CSUM_EN  when defined, csum is live; otherwise tied to 0.
module shadowmask_cmd_gen #(
    parameter int unsigned GAP = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cfg_enable,
    input  logic        cfg_rotate,
    input  logic        cfg_2x,
    input  logic [3:0]  cfg_vmax,
    input  logic [3:0]  cfg_hmax,
    input  logic [8:0]  lut_count,
    input  logic        lut_wr,
    input  logic [7:0]  lut_addr,
    input  logic [10:0] lut_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        cmd_wr,
    output logic [15:0] cmd_out,
    output logic [15:0] csum
);

    localparam int unsigned CMD_W     = 16;
    localparam int unsigned LUT_W     = 11;
    localparam int unsigned LUT_DEPTH = 256;
    localparam int unsigned CNT_W     = 9;
    localparam int unsigned GAP_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_VMAX, S_HMAX, S_LUT, S_WAIT, S_FIN
    } state_t;

    state_t             state_q;
    state_t             ret_q;
    logic [GAP_W-1:0]   gap_q;
    logic [3:0]         vmax_q;
    logic [3:0]         hmax_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   sent_q;
    logic [7:0]         rd_ptr_q;
    logic [LUT_W-1:0]   rd_data_q;
    logic [LUT_W-1:0]   ram [LUT_DEPTH];

    state_t             after_c;
    state_t             kind_c;
    logic               issue_c;
    logic               go_c;
    logic               cmd_state_c;
    logic               rd_load_c;
    logic [CMD_W-1:0]   word_c;

    assign go_c        = start && (state_q == S_IDLE);
    assign cmd_state_c = (state_q == S_HDR) || (state_q == S_VMAX) ||
                         (state_q == S_HMAX) || (state_q == S_LUT);

    // What follows the command strobing in the current cycle.
    always_comb begin
        after_c = S_FIN;
        case (state_q)
            S_HDR:   after_c = S_VMAX;
            S_VMAX:  after_c = S_HMAX;
            S_HMAX:  after_c = (n_q == '0) ? S_FIN : S_LUT;
            S_LUT:   after_c = (sent_q == n_q) ? S_FIN : S_LUT;
            default: after_c = S_FIN;
        endcase
    end

    // Whether a command is launched at this edge, and which one.
    always_comb begin
        issue_c = 1'b0;
        kind_c  = S_HDR;
        if (state_q == S_IDLE) begin
            issue_c = start;
            kind_c  = S_HDR;
        end else if (cmd_state_c && (after_c != S_FIN) && (GAP == 0)) begin
            issue_c = 1'b1;
            kind_c  = after_c;
        end else if ((state_q == S_WAIT) && (gap_q == '0)) begin
            issue_c = 1'b1;
            kind_c  = ret_q;
        end
    end

    // HDR is only launched on the start edge, so it takes the cfg inputs directly.
    always_comb begin
        case (kind_c)
            S_HDR:   word_c = {3'b000, 9'b0, cfg_enable, cfg_rotate, cfg_2x, 1'b0};
            S_VMAX:  word_c = {3'b001, 9'b0, vmax_q};
            S_HMAX:  word_c = {3'b010, 9'b0, hmax_q};
            default: word_c = {3'b011, 2'b00, rd_data_q};
        endcase
    end

    // rd_data_q always holds the next entry to send: primed during HDR,
    // refilled from rd_ptr_q each time an entry is launched.
    assign rd_load_c = (state_q == S_HDR) || (issue_c && (kind_c == S_LUT));

    // LUT buffer: write port for the loader, synchronous prefetch read.
    always_ff @(posedge clk_sys) begin
        if (lut_wr && !busy) begin
            ram[lut_addr] <= lut_data;
        end
        if (rd_load_c) begin
            rd_data_q <= ram[rd_ptr_q];
        end
    end

    // Sequencer with registered strobe/status outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ret_q    <= S_IDLE;
            gap_q    <= '0;
            vmax_q   <= '0;
            hmax_q   <= '0;
            n_q      <= '0;
            sent_q   <= '0;
            rd_ptr_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cmd_wr   <= 1'b0;
            cmd_out  <= '0;
        end else begin
            cmd_wr <= issue_c;
            done   <= 1'b0;
            if (issue_c) begin
                cmd_out <= word_c;
                state_q <= kind_c;
            end
            if (rd_load_c) begin
                rd_ptr_q <= rd_ptr_q + 8'd1;
            end
            if (issue_c && (kind_c == S_LUT)) begin
                sent_q <= sent_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (go_c) begin
                        vmax_q   <= cfg_vmax;
                        hmax_q   <= cfg_hmax;
                        n_q      <= (lut_count > CNT_W'(LUT_DEPTH)) ? CNT_W'(LUT_DEPTH) : lut_count;
                        sent_q   <= '0;
                        rd_ptr_q <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_HDR, S_VMAX, S_HMAX, S_LUT: begin
                    // The final command is never followed by a gap.
                    if (after_c == S_FIN) begin
                        state_q <= S_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (GAP != 0) begin
                        state_q <= S_WAIT;
                        ret_q   <= after_c;
                        gap_q   <= GAP_W'(GAP - 1);
                    end
                end
                S_WAIT: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SHADOWMASK_CMD_CSUM_EN
    logic [CMD_W-1:0] csum_q;

    // Sum of every word at its strobe; the last add lands in the done cycle.
    always_ff @(posedge clk_sys) begin
        if (reset || go_c) begin
            csum_q <= '0;
        end else if (cmd_wr) begin
            csum_q <= csum_q + cmd_out;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_shadowmask_cmd_gen.sv
// Directed self-checking bench for shadowmask_cmd_gen, with one GAP=0 and one
// GAP=1 instance sharing the loader/config inputs and separate starts.
module tb_shadowmask_cmd_gen;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset;
    logic        cfg_enable, cfg_rotate, cfg_2x;
    logic [3:0]  cfg_vmax, cfg_hmax;
    logic [8:0]  lut_count;
    logic        lut_wr;
    logic [7:0]  lut_addr;
    logic [10:0] lut_data;
    logic        start0, start1;
    logic        busy0, done0, wr0, busy1, done1, wr1;
    logic [15:0] out0, cs0, out1, cs1;

`ifdef SHADOWMASK_CMD_CSUM_EN
    localparam logic [15:0] CS_T1 = 16'h600F;
    localparam logic [15:0] CS_T2 = 16'hF0A4;
`else
    localparam logic [15:0] CS_T1 = 16'h0000;
    localparam logic [15:0] CS_T2 = 16'h0000;
`endif

    shadowmask_cmd_gen #(.GAP(0)) u_gap0 (
        .clk_sys(clk_sys), .reset(reset),
        .cfg_enable(cfg_enable), .cfg_rotate(cfg_rotate), .cfg_2x(cfg_2x),
        .cfg_vmax(cfg_vmax), .cfg_hmax(cfg_hmax), .lut_count(lut_count),
        .lut_wr(lut_wr), .lut_addr(lut_addr), .lut_data(lut_data),
        .start(start0), .busy(busy0), .done(done0),
        .cmd_wr(wr0), .cmd_out(out0), .csum(cs0)
    );

    shadowmask_cmd_gen #(.GAP(1)) u_gap1 (
        .clk_sys(clk_sys), .reset(reset),
        .cfg_enable(cfg_enable), .cfg_rotate(cfg_rotate), .cfg_2x(cfg_2x),
        .cfg_vmax(cfg_vmax), .cfg_hmax(cfg_hmax), .lut_count(lut_count),
        .lut_wr(lut_wr), .lut_addr(lut_addr), .lut_data(lut_data),
        .start(start1), .busy(busy1), .done(done1),
        .cmd_wr(wr1), .cmd_out(out1), .csum(cs1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic lut_write(input logic [7:0] a, input logic [10:0] d);
        lut_wr   = 1'b1;
        lut_addr = a;
        lut_data = d;
        step();
        lut_wr   = 1'b0;
    endtask

    task automatic set_cfg(input logic en, input logic rot, input logic x2,
                           input logic [3:0] vm, input logic [3:0] hm, input logic [8:0] cnt);
        cfg_enable = en;
        cfg_rotate = rot;
        cfg_2x     = x2;
        cfg_vmax   = vm;
        cfg_hmax   = hm;
        lut_count  = cnt;
    endtask

    // Results of the most recent run_seq (cycle offsets are relative to T).
    logic [15:0] sw[$];
    int          st[$];
    int          done_at;
    int          busy_err;
    logic [15:0] csum_done;
    logic [15:0] hold2;

    // Start one instance at T, scramble the cfg inputs, then record strobes until
    // done or the cycle budget runs out. inj_cyc>0 pulses start plus a LUT write
    // to address 0 in that cycle. Returns in the cycle after done.
    task automatic run_seq(input bit sel, input int max_cyc, input int inj_cyc);
        logic w, d, b;
        logic [15:0] o, c;
        sw.delete();
        st.delete();
        done_at   = -1;
        busy_err  = 0;
        csum_done = 16'hDEAD;
        hold2     = 16'hDEAD;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        step();
        start0 = 1'b0; start1 = 1'b0; lut_wr = 1'b0;
        set_cfg(~cfg_enable, ~cfg_rotate, ~cfg_2x, 4'hF, 4'hF, 9'h1FF);
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            w = sel ? wr1   : wr0;
            d = sel ? done1 : done0;
            b = sel ? busy1 : busy0;
            o = sel ? out1  : out0;
            c = sel ? cs1   : cs0;
            if (cyc == 2) hold2 = o;
            if (w) begin
                sw.push_back(o);
                st.push_back(cyc);
                if (!b) busy_err++;
            end
            if (d) begin
                done_at   = cyc;
                csum_done = c;
                if (b) busy_err++;
                break;
            end
            if (cyc == inj_cyc) begin
                if (sel) start1 = 1'b1; else start0 = 1'b1;
                lut_wr   = 1'b1;
                lut_addr = 8'd0;
                lut_data = 11'h2AA;
            end
            step();
            start0 = 1'b0; start1 = 1'b0; lut_wr = 1'b0;
        end
        step();
    endtask

    initial begin
        int stray;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        lut_wr = 1'b0; lut_addr = '0; lut_data = '0;
        set_cfg(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 9'd0);
        repeat (3) step();

        // Reset state of both instances.
        chk("rst_wr0",   32'(wr0),   32'h0);
        chk("rst_out0",  32'(out0),  32'h0);
        chk("rst_busy0", 32'(busy0), 32'h0);
        chk("rst_done0", 32'(done0), 32'h0);
        chk("rst_csum0", 32'(cs0),   32'h0);
        chk("rst_wr1",   32'(wr1),   32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);
        chk("rst_csum1", 32'(cs1),   32'h0);
        reset = 1'b0;
        step();

        // GAP=1, N=0: header, vmax, hmax only.
        set_cfg(1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 9'd0);
        run_seq(1'b1, 20, 0);
        chk("t1_count", 32'(st.size()), 32'd3);
        chk("t1_t0",    32'(st[0]), 32'd1);
        chk("t1_t1",    32'(st[1]), 32'd3);
        chk("t1_t2",    32'(st[2]), 32'd5);
        chk("t1_hdr",   32'(sw[0]), 32'h000A);
        chk("t1_vmax",  32'(sw[1]), 32'h2002);
        chk("t1_hmax",  32'(sw[2]), 32'h4003);
        chk("t1_hold",  32'(hold2), 32'h000A);
        chk("t1_done",  32'(done_at), 32'd6);
        chk("t1_busy",  32'(busy_err), 32'd0);
        chk("t1_csum",  32'(csum_done), 32'(CS_T1));

        // GAP=0, four entries, back-to-back.
        lut_write(8'd0, 11'h7F0);
        lut_write(8'd1, 11'h0A5);
        lut_write(8'd2, 11'h401);
        lut_write(8'd3, 11'h3FF);
        set_cfg(1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 9'd4);
        run_seq(1'b0, 20, 0);
        chk("t2_count", 32'(st.size()), 32'd7);
        chk("t2_first", 32'(st[0]), 32'd1);
        chk("t2_last",  32'(st[6]), 32'd7);
        chk("t2_hdr",   32'(sw[0]), 32'h000A);
        chk("t2_lut0",  32'(sw[3]), 32'h67F0);
        chk("t2_lut1",  32'(sw[4]), 32'h60A5);
        chk("t2_lut2",  32'(sw[5]), 32'h6401);
        chk("t2_lut3",  32'(sw[6]), 32'h63FF);
        chk("t2_done",  32'(done_at), 32'd8);
        chk("t2_busy",  32'(busy_err), 32'd0);
        chk("t2_csum",  32'(csum_done), 32'(CS_T2));

        // Fill the whole buffer with entry i = 7*i+3; lut_count=300 clamps to 256.
        for (int i = 0; i < 256; i++) lut_write(8'(i), 11'(i * 7 + 3));
        set_cfg(1'b0, 1'b1, 1'b0, 4'd5, 4'd6, 9'd300);
        run_seq(1'b0, 400, 0);
        chk("t3_count", 32'(st.size()), 32'd259);
        chk("t3_hdr",   32'(sw[0]), 32'h0004);
        chk("t3_vmax",  32'(sw[1]), 32'h2005);
        chk("t3_hmax",  32'(sw[2]), 32'h4006);
        chk("t3_e100",  32'(sw[103]), 32'h62BF);
        chk("t3_e255",  32'(sw[258]), 32'h66FC);
        chk("t3_tlast", 32'(st[258]), 32'd259);
        chk("t3_done",  32'(done_at), 32'd260);

        // GAP=1, N=256: 259 strobes over T+1..T+517.
        set_cfg(1'b0, 1'b1, 1'b0, 4'd5, 4'd6, 9'd256);
        run_seq(1'b1, 600, 0);
        chk("t3g_count", 32'(st.size()), 32'd259);
        chk("t3g_tlast", 32'(st[258]), 32'd517);
        chk("t3g_e255",  32'(sw[258]), 32'h66FC);
        chk("t3g_done",  32'(done_at), 32'd518);

        // Write coincident with start is used; start and write while busy are not.
        set_cfg(1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 9'd1);
        lut_wr = 1'b1; lut_addr = 8'd0; lut_data = 11'h155;
        run_seq(1'b0, 20, 2);
        chk("t4_count", 32'(st.size()), 32'd4);
        chk("t4_lut0",  32'(sw[3]), 32'h6155);
        chk("t4_done",  32'(done_at), 32'd5);
        set_cfg(1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 9'd1);
        run_seq(1'b0, 20, 0);
        chk("t4r_count", 32'(st.size()), 32'd4);
        chk("t4r_lut0",  32'(sw[3]), 32'h6155);
        chk("t4r_done",  32'(done_at), 32'd5);

        // Reset during the k=5 strobe of an N=16 run.
        set_cfg(1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 9'd16);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (5) step();
        chk("t5_k5_wr",  32'(wr0),  32'h1);
        chk("t5_k5_out", 32'(out0), 32'h6011);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_wr",   32'(wr0),   32'h0);
        chk("t5_rst_busy", 32'(busy0), 32'h0);
        chk("t5_rst_done", 32'(done0), 32'h0);
        chk("t5_rst_csum", 32'(cs0),   32'h0);
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            if (wr0 || done0 || busy0) stray++;
            step();
        end
        chk("t5_quiet", 32'(stray), 32'd0);
        set_cfg(1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 9'd16);
        run_seq(1'b0, 40, 0);
        chk("t5r_count", 32'(st.size()), 32'd19);
        chk("t5r_e15",   32'(sw[18]), 32'h606C);
        chk("t5r_done",  32'(done_at), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
